// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the pipelined ALU: opcode encodings,
//               flag bit positions, the result record and the compute
//               function used by the combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int MAX_WIDTH = 64;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] res;
        logic                 wr;
        logic [3:0]           flags;
    } alu_result_t;

    // Operands arrive zero-extended to MAX_WIDTH; 'width' is the active
    // datapath width and is a constant at every call site, so the masking
    // and variable bit selects fold away in synthesis.
    function automatic alu_result_t alu_compute(
        input logic [2:0]           op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] am;
        logic [MAX_WIDTH-1:0] bm;
        logic [MAX_WIDTH-1:0] r;
        logic [MAX_WIDTH:0]   sum;
        logic [6:0]           wbits;
        logic [5:0]           msb;
        logic [5:0]           sh;
        logic                 c;
        logic                 o;
        alu_result_t          result;

        wbits = 7'(width);
        msb   = 6'(width - 1);
        mask  = (width >= MAX_WIDTH) ? {MAX_WIDTH{1'b1}}
                                     : ((64'd1 << wbits) - 64'd1);
        am    = a & mask;
        bm    = b & mask;
        // width is a power of two, so width-1 masks the shift amount
        sh    = am[5:0] & msb;
        sum   = '0;
        r     = '0;
        c     = 1'b0;
        o     = 1'b0;

        case (op)
            OP_ADD: begin
                sum = {1'b0, am} + {1'b0, bm};
                r   = sum[MAX_WIDTH-1:0] & mask;
                c   = sum[wbits];
                o   = (am[msb] == bm[msb]) && (r[msb] != am[msb]);
            end
            OP_SUB, OP_CMP: begin
                sum = {1'b0, bm} - {1'b0, am};
                r   = sum[MAX_WIDTH-1:0] & mask;
                c   = (bm < am);
                o   = (am[msb] != bm[msb]) && (r[msb] != bm[msb]);
            end
            OP_SHL: begin
                r = (bm << sh) & mask;
                // last bit out of the top is b[width-sh]
                c = (sh != 6'd0) ? bm[6'(wbits - {1'b0, sh})] : 1'b0;
            end
            OP_SHR: begin
                r = bm >> sh;
                c = (sh != 6'd0) ? bm[sh - 6'd1] : 1'b0;
            end
            OP_OR:   r = am | bm;
            OP_AND:  r = am & bm;
            OP_XOR:  r = am ^ bm;
            default: r = '0;
        endcase

        result.res            = r;
        result.wr             = (op != OP_CMP);
        result.flags          = '0;
        result.flags[FLAG_Z]  = (r == '0);
        result.flags[FLAG_S]  = r[msb];
        result.flags[FLAG_C]  = c;
        result.flags[FLAG_O]  = o;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU compute unit.
//   op    in  3      opcode
//   a     in  WIDTH  operand a (shift amount source for SHL/SHR)
//   b     in  WIDTH  operand b
//   res   out WIDTH  result
//   wr    out 1      result to be written back (0 for CMP)
//   flags out 4      {O,C,S,Z}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             wr,
    output logic [3:0]       flags
);

    alu_result_t w_result;

    assign w_result = alu_compute(op, MAX_WIDTH'(a), MAX_WIDTH'(b), WIDTH);
    assign res      = w_result.res[WIDTH-1:0];
    assign wr       = w_result.wr;
    assign flags    = w_result.flags;

    // Upper result bits are always zero for narrow widths.
    generate
        if (WIDTH < MAX_WIDTH) begin : g_narrow
            logic w_unused_hi;
            assign w_unused_hi = ^w_result.res[MAX_WIDTH-1:WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with valid/ready handshakes and an
//               architectural flags register.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_op, in_a, in_b operation
//   out_valid/ready output handshake; out_res, out_wr, out_flags result
//   flags           architectural {O,C,S,Z}, loaded on each output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_wr,
    output logic [3:0]       out_flags,
    output logic [3:0]       flags
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic             r_s2_wr;
    logic [3:0]       r_s2_flags;

    logic [3:0]       r_flags;

    logic             w_s2_adv;
    logic [WIDTH-1:0] w_res;
    logic             w_wr;
    logic [3:0]       w_flags;

    // Ready ripples back combinationally so a full stream never bubbles.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= in_op;
                r_s1_a  <= in_a;
                r_s1_b  <= in_b;
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op    (r_s1_op),
        .a     (r_s1_a),
        .b     (r_s1_b),
        .res   (w_res),
        .wr    (w_wr),
        .flags (w_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_wr    <= 1'b0;
            r_s2_flags <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_res   <= w_res;
                r_s2_wr    <= w_wr;
                r_s2_flags <= w_flags;
            end
        end
    end

    // CMP results update the flags too; only the write-back is suppressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_flags <= r_s2_flags;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_res   = r_s2_res;
    assign out_wr    = r_s2_wr;
    assign out_flags = r_s2_flags;
    assign flags     = r_flags;

endmodule
`default_nettype wire
